main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit for the MIPS datapath. It sits directly upstream of the ALU control decoder: it sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, plus the 3-bit ALUOp that the ALU control decoder combines with Func to form the 4-bit ALU select. Memory accesses stall on a ready handshake, and a retired-instruction counter supports debug.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Op  in  6  instruction opcode (IR[31:26]), sampled in DECODE and MEM_ADDR
- MemReady  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  out  3  000 R-type (use Func), 010 add, 110 subtract
- IllegalOp  out  1  single-cycle pulse on an unsupported opcode
- Retire  out  1  single-cycle pulse on the last cycle of a legal instruction
- InstrCount  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are decoded from the registered state.
- Outputs not listed for a state are 0, except ALUOp, which defaults to 010.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=010. IRWrite=PCWrite=MemReady.
  - Hold while !MemReady; go to DECODE on MemReady.
- DECODE: ALUSrcB=11, ALUOp=010. Next state by Op:
  - lw/sw -> MEM_ADDR
  - R-type -> R_EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - any other opcode -> FETCH, with IllegalOp=1 this cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1. Hold until MemReady, then -> MEM_WB.
- MEM_WB: MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Hold until MemReady, then -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=000 -> R_WB.
- R_WB: RegDst=1, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUOp=110, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10 -> ADDI_WB.
- ADDI_WB: RegWrite=1 -> FETCH.
- Retire=1 on each transition to FETCH from a non-DECODE state. MEM_WRITE counts only on its MemReady cycle.
- InstrCount increments on Retire, wraps modulo 2^CNT_W, and never counts illegal opcodes.

## Timing
- Reset: state=FETCH, InstrCount=0.
  - While rst is high, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, Retire and IllegalOp are forced to 0, regardless of MemReady.
  - Reset mid-instruction aborts the instruction immediately, with no retire.
- Cycles per instruction with MemReady=1 throughout:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3
  - illegal opcode 2 (FETCH, DECODE)
- Each cycle of MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. No enable pulses while stalled.
- MemReady is ignored in all other states.
- Retire and the InstrCount update coincide: the counter shows the new value the cycle after Retire.

## Structure
- Shared package holds:
  - opcode constants
  - ALUOp encodings (000/010/110), shared with the ALU control decoder
  - ALUSrcB and PCSource encodings
  - 4-bit state enumeration, 12 states
- Natural sub-module: ctrl_retire_counter, a CNT_W counter with increment enable and async reset.

## Test plan
- Reset asserted mid-MEM_READ -> state FETCH, InstrCount=0, all write enables 0 while rst=1, even with MemReady=1.
- R-type (Op=0) with MemReady=1 -> states FETCH, DECODE, R_EXEC, R_WB; ALUOp=000 in R_EXEC; RegDst=1, RegWrite=1 in R_WB; Retire once; InstrCount 0->1.
- lw with MemReady low 3 cycles in MEM_READ -> 8 total cycles; IorD=1, MemRead=1 held; MemtoReg=1, RegWrite=1 in MEM_WB.
- beq (Op=4) -> ALUOp=110, PCWriteCond=1, PCSource=01 for exactly one cycle; 3 cycles total.
- Op=111111 -> IllegalOp pulses in DECODE, next state FETCH, InstrCount unchanged.
- CNT_W=4: 16 j instructions retire -> InstrCount wraps to 0; PCSource=10, PCWrite=1 in each JUMP cycle.

Source files
------------

// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared encodings for the multi-cycle MIPS main control unit
//
// Purpose: opcode constants, ALUOp / ALUSrcB / PCSource encodings and the
// 12-state enumeration used by main_control_fsm. The ALUOp encodings are
// shared with the downstream ALU control decoder.
// Ports: none (package).

package main_control_fsm_pkg;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp encodings, combined with Func by the ALU control decoder
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states (4-bit, 12 used)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  // Dispatch target out of DECODE; unsupported opcodes return to FETCH.
  function automatic logic [3:0] decode_dispatch(input logic [5:0] op);
    logic [3:0] nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_RTYPE:     nxt = S_R_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = S_ADDI_EXEC;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/main_control_fsm_ctrl_retire_counter.sv
// rtl/main_control_fsm_ctrl_retire_counter.sv - retired-instruction counter
//
// Purpose: CNT_W-bit up counter with increment enable; wraps modulo 2^CNT_W.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset (count -> 0)
//   en    in  1      increment this cycle
//   count out CNT_W  current count

module ctrl_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle MIPS main control unit
//
// Purpose: sequences each instruction through fetch, decode, execute,
// memory and writeback, driving all datapath enables and mux selects plus
// the 3-bit ALUOp for the ALU control decoder. Memory states stall on
// MemReady. A retired-instruction counter supports debug.
// Ports:
//   clk, rst                         clock, async active-high reset
//   Op[5:0]                          opcode, sampled in DECODE and MEM_ADDR
//   MemReady                         memory completes current access
//   PCWrite .. ALUSrcA               1-bit datapath controls
//   ALUSrcB[1:0], PCSource[1:0]      mux selects
//   ALUOp[2:0]                       ALU operation class
//   IllegalOp                        pulse on unsupported opcode in DECODE
//   Retire                           pulse on last cycle of a legal instruction
//   InstrCount[CNT_W-1:0]            retired-instruction count

module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic             IllegalOp,
  output logic             Retire,
  output logic [CNT_W-1:0] InstrCount
);

  logic [3:0] state;
  logic [3:0] next_state;

  // Raw (ungated) versions of the enables that must be forced low in reset
  logic pcwrite_raw, pcwritecond_raw, irwrite_raw, memwrite_raw;
  logic regwrite_raw, retire_raw, illegal_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    pcwrite_raw     = 1'b0;
    pcwritecond_raw = 1'b0;
    irwrite_raw     = 1'b0;
    memwrite_raw    = 1'b0;
    regwrite_raw    = 1'b0;
    retire_raw      = 1'b0;
    illegal_raw     = 1'b0;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = SRCB_REG;
    PCSource        = PCSRC_ALU;
    ALUOp           = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        MemRead     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        // PC+4 and IR latch only on the cycle the fetch completes
        irwrite_raw = MemReady;
        pcwrite_raw = MemReady;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB     = SRCB_IMM_SH2;
        next_state  = decode_dispatch(Op);
        illegal_raw = !is_supported_op(Op);
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        // Op should still be lw/sw here; anything else abandons quietly
        if (Op == OP_LW)      next_state = S_MEM_READ;
        else if (Op == OP_SW) next_state = S_MEM_WRITE;
        else                  next_state = S_FETCH;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg     = 1'b1;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
        // sw retires only when the store is accepted
        if (MemReady) begin
          retire_raw = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_RTYPE;
        next_state = S_R_WB;
      end
      S_R_WB: begin
        RegDst       = 1'b1;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUOp           = ALUOP_SUB;
        pcwritecond_raw = 1'b1;
        PCSource        = PCSRC_ALUOUT;
        retire_raw      = 1'b1;
        next_state      = S_FETCH;
      end
      S_JUMP: begin
        pcwrite_raw = 1'b1;
        PCSource    = PCSRC_JUMP;
        retire_raw  = 1'b1;
        next_state  = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // State sits at FETCH during reset, where MemReady would otherwise reach
  // PCWrite/IRWrite combinationally; gate every architectural write here.
  assign PCWrite     = pcwrite_raw     & ~rst;
  assign PCWriteCond = pcwritecond_raw & ~rst;
  assign IRWrite     = irwrite_raw     & ~rst;
  assign MemWrite    = memwrite_raw    & ~rst;
  assign RegWrite    = regwrite_raw    & ~rst;
  assign Retire      = retire_raw      & ~rst;
  assign IllegalOp   = illegal_raw     & ~rst;

  ctrl_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (Retire),
    .count (InstrCount)
  );

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - directed self-checking bench for main_control_fsm

module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  Op = 6'b0;
  logic        MemReady = 1'b1;
  logic [18:0] ctl;
  logic [18:0] ctl4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Control vector layout:
  // [18] PCWrite [17] PCWriteCond [16] IorD [15] MemRead [14] MemWrite
  // [13] MemtoReg [12] IRWrite [11] RegWrite [10] RegDst [9] ALUSrcA
  // [8:7] ALUSrcB [6:5] PCSource [4:2] ALUOp [1] IllegalOp [0] Retire
  main_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
    .PCWrite(ctl[18]), .PCWriteCond(ctl[17]), .IorD(ctl[16]), .MemRead(ctl[15]),
    .MemWrite(ctl[14]), .MemtoReg(ctl[13]), .IRWrite(ctl[12]), .RegWrite(ctl[11]),
    .RegDst(ctl[10]), .ALUSrcA(ctl[9]), .ALUSrcB(ctl[8:7]), .PCSource(ctl[6:5]),
    .ALUOp(ctl[4:2]), .IllegalOp(ctl[1]), .Retire(ctl[0]), .InstrCount(cnt)
  );

  main_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
    .PCWrite(ctl4[18]), .PCWriteCond(ctl4[17]), .IorD(ctl4[16]), .MemRead(ctl4[15]),
    .MemWrite(ctl4[14]), .MemtoReg(ctl4[13]), .IRWrite(ctl4[12]), .RegWrite(ctl4[11]),
    .RegDst(ctl4[10]), .ALUSrcA(ctl4[9]), .ALUSrcB(ctl4[8:7]), .PCSource(ctl4[6:5]),
    .ALUOp(ctl4[4:2]), .IllegalOp(ctl4[1]), .Retire(ctl4[0]), .InstrCount(cnt4)
  );

  // Hand-computed expected control vectors per state
  localparam logic [18:0] V_FETCH_OK = {10'b1001001000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_FETCH_ST = {10'b0001000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_RESET    = {10'b0001000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_DEC      = {10'b0000000000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_DEC_ILL  = {10'b0000000000, 2'b11, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam logic [18:0] V_MADDR    = {10'b0000000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MREAD    = {10'b0011000000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MWB      = {10'b0000010100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
  localparam logic [18:0] V_MWR_ST   = {10'b0010100000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_MWR_OK   = {10'b0010100000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
  localparam logic [18:0] V_REX      = {10'b0000000001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] V_RWB      = {10'b0000000110, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
  localparam logic [18:0] V_BR       = {10'b0100000001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b1};
  localparam logic [18:0] V_JMP      = {10'b1000000000, 2'b00, 2'b10, 3'b010, 1'b0, 1'b1};
  localparam logic [18:0] V_AEX      = {10'b0000000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam logic [18:0] V_AWB      = {10'b0000000100, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs are set just after a rising edge; outputs sampled on the falling edge.
  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge clk);
    chk(tag, {13'b0, ctl}, {13'b0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with MemReady high: all write enables forced low
    rst = 1'b1; MemReady = 1'b1; Op = 6'b0;
    @(negedge clk);
    chk("rst_ctl", {13'b0, ctl}, {13'b0, V_RESET});
    chk("rst_cnt", cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type: 4 cycles, one retire
    Op = 6'b000000;
    cyc("r_fetch", V_FETCH_OK);
    cyc("r_dec", V_DEC);
    cyc("r_exec", V_REX);
    chk("r_cnt_before", cnt, 32'd0);
    cyc("r_wb", V_RWB);
    chk("r_cnt_after", cnt, 32'd1);

    // lw with MemReady low 3 cycles in MEM_READ: 8 cycles
    Op = 6'b100011;
    cyc("lw_fetch", V_FETCH_OK);
    cyc("lw_dec", V_DEC);
    MemReady = 1'b0;
    cyc("lw_addr", V_MADDR);
    cyc("lw_rd_st0", V_MREAD);
    cyc("lw_rd_st1", V_MREAD);
    cyc("lw_rd_st2", V_MREAD);
    MemReady = 1'b1;
    cyc("lw_rd_ok", V_MREAD);
    cyc("lw_wb", V_MWB);
    chk("lw_cnt", cnt, 32'd2);

    // beq: 3 cycles
    Op = 6'b000100;
    cyc("beq_fetch", V_FETCH_OK);
    cyc("beq_dec", V_DEC);
    cyc("beq_br", V_BR);
    chk("beq_cnt", cnt, 32'd3);

    // Illegal opcode: 2 cycles, no retire
    Op = 6'b111111;
    cyc("ill_fetch", V_FETCH_OK);
    cyc("ill_dec", V_DEC_ILL);
    chk("ill_cnt", cnt, 32'd3);

    // sw with a fetch stall and a store stall
    Op = 6'b101011;
    MemReady = 1'b0;
    cyc("sw_fetch_st", V_FETCH_ST);
    MemReady = 1'b1;
    cyc("sw_fetch", V_FETCH_OK);
    cyc("sw_dec", V_DEC);
    MemReady = 1'b0;
    cyc("sw_addr", V_MADDR);
    cyc("sw_wr_st", V_MWR_ST);
    chk("sw_cnt_stall", cnt, 32'd3);
    MemReady = 1'b1;
    cyc("sw_wr_ok", V_MWR_OK);
    chk("sw_cnt", cnt, 32'd4);

    // addi: 4 cycles
    Op = 6'b001000;
    cyc("addi_fetch", V_FETCH_OK);
    cyc("addi_dec", V_DEC);
    cyc("addi_exec", V_AEX);
    cyc("addi_wb", V_AWB);
    chk("addi_cnt", cnt, 32'd5);

    // Reset asserted mid-MEM_READ
    Op = 6'b100011;
    cyc("abort_fetch", V_FETCH_OK);
    cyc("abort_dec", V_DEC);
    MemReady = 1'b0;
    cyc("abort_addr", V_MADDR);
    cyc("abort_rd", V_MREAD);
    rst = 1'b1; MemReady = 1'b1;
    #1;
    chk("abort_ctl_async", {13'b0, ctl}, {13'b0, V_RESET});
    chk("abort_cnt_async", cnt, 32'd0);
    cyc("abort_ctl", V_RESET);
    chk("abort_cnt", cnt, 32'd0);
    chk("abort_cnt4", {28'b0, cnt4}, 32'd0);
    rst = 1'b0;

    // 16 jumps: 4-bit counter wraps to 0, 32-bit counter reaches 16
    Op = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      cyc("j_fetch", V_FETCH_OK);
      cyc("j_dec", V_DEC);
      cyc("j_jump", V_JMP);
    end
    chk("j_cnt4_wrap", {28'b0, cnt4}, 32'd0);
    chk("j_cnt32", cnt, 32'd16);
    chk("j_ctl4_fetch", {13'b0, ctl4}, {13'b0, V_FETCH_OK});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
